// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Multi-cycle sequencer for the datapath. It steps each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB and drives the per-state strobes for
// the PC, instruction register, ALU, data memory and register file. Memory
// accesses wait on a variable-latency handshake (mem_ready). One instruction
// is in flight at a time. Retired instructions are counted. Illegal opcodes
// and memory timeouts lock the sequencer in ERROR until reset.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   run          level; enables instruction sequencing (sampled in IDLE and
//                at retire only)
//   op[5:0]      opcode from the instruction register output
//   mem_ready    memory completes the current read/write this cycle
//   PCWrite      PC update strobe
//   IRWrite      instruction register load strobe
//   MemRead      memory read request
//   MemToWrite   memory write request
//   MemToReg     writeback source select (1 = memory, 0 = ALU)
//   ALUOp[2:0]   ALU operation select
//   RegWrite     register file write strobe
//   busy         high in every state except IDLE and ERROR
//   instr_done   one-cycle retire pulse
//   instr_count  retired-instruction counter (wraps)
//   error        sticky fault flag
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemToWrite,
  output logic             MemToReg,
  output logic [2:0]       ALUOp,
  output logic             RegWrite,
  output logic             busy,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERROR  = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;

  localparam logic [TO_W-1:0] TIMEOUT = TO_W'(MEM_TIMEOUT);

  state_t            state;
  state_t            nextState;
  logic [5:0]        opQ;
  logic [TO_W-1:0]   waitCnt;
  logic [CNT_W-1:0]  instrCount;
  logic              waitExpired;
  logic              enterWaitState;

  function automatic logic isLegal(input logic [5:0] o);
    return (o == OP_RTYPE) || (o == OP_LW) || (o == OP_SW) || (o == OP_ADDI);
  endfunction

  function automatic logic isMemOp(input logic [5:0] o);
    return (o == OP_LW) || (o == OP_SW);
  endfunction

  // A memory-wait state gives up only when the budget is used and the memory
  // still has not answered; a ready on the final cycle wins.
  assign waitExpired = (waitCnt == TIMEOUT) && !mem_ready;

  // The wait counter restarts whenever FETCH or MEM is freshly entered,
  // including FETCH reached directly from a retire.
  assign enterWaitState = ((nextState == FETCH) || (nextState == MEM)) &&
                          (nextState != state);

  // ---- state register and sequencing state --------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      opQ        <= '0;
      waitCnt    <= '0;
      instrCount <= '0;
    end else begin
      state <= nextState;

      if (state == DECODE) begin
        opQ <= op;
      end

      if (enterWaitState) begin
        waitCnt <= '0;
      end else if (((state == FETCH) || (state == MEM)) && !mem_ready) begin
        waitCnt <= waitCnt + 1'b1;
      end

      if (instr_done) begin
        instrCount <= instrCount + 1'b1;
      end
    end
  end

  // ---- next-state and Moore outputs ----------------------------------------
  always_comb begin
    nextState  = state;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemToWrite = 1'b0;
    MemToReg   = 1'b0;
    ALUOp      = ALU_RTYPE;
    RegWrite   = 1'b0;
    busy       = 1'b0;
    instr_done = 1'b0;
    error      = 1'b0;

    unique case (state)
      IDLE: begin
        if (run) nextState = FETCH;
      end

      FETCH: begin
        busy    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          nextState = DECODE;
        end else if (waitExpired) begin
          nextState = ERROR;
        end
      end

      DECODE: begin
        busy      = 1'b1;
        nextState = isLegal(op) ? EXEC : ERROR;
      end

      EXEC: begin
        busy      = 1'b1;
        ALUOp     = (opQ == OP_RTYPE) ? ALU_RTYPE : ALU_ADD;
        nextState = isMemOp(opQ) ? MEM : WB;
      end

      MEM: begin
        busy = 1'b1;
        if (opQ == OP_SW) begin
          MemToWrite = 1'b1;
        end else begin
          MemRead = 1'b1;
        end
        if (mem_ready) begin
          if (opQ == OP_SW) begin
            // Stores have nothing to write back, so they retire here.
            instr_done = 1'b1;
            nextState  = run ? FETCH : IDLE;
          end else begin
            nextState = WB;
          end
        end else if (waitExpired) begin
          nextState = ERROR;
        end
      end

      WB: begin
        busy       = 1'b1;
        RegWrite   = 1'b1;
        MemToReg   = (opQ == OP_LW);
        instr_done = 1'b1;
        nextState  = run ? FETCH : IDLE;
      end

      ERROR: begin
        error = 1'b1;
      end

      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign instr_count = instrCount;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  // Narrow counter so the wrap is reachable in a short run.
  localparam int TB_CNT_W = 8;

  logic                clk;
  logic                reset;
  logic                run;
  logic [5:0]          op;
  logic                mem_ready;
  logic                PCWrite;
  logic                IRWrite;
  logic                MemRead;
  logic                MemToWrite;
  logic                MemToReg;
  logic [2:0]          ALUOp;
  logic                RegWrite;
  logic                busy;
  logic                instr_done;
  logic [TB_CNT_W-1:0] instr_count;
  logic                error;

  int checks   = 0;
  int failures = 0;
  int expCount = 0;
  logic [TB_CNT_W-1:0] expQ [$];

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Output vector: {PCWrite,IRWrite,MemRead,MemToWrite,MemToReg,ALUOp,RegWrite,busy,instr_done,error}
  localparam logic [11:0] V_IDLE = 12'b0_0_0_0_0_000_0_0_0_0;
  localparam logic [11:0] V_FWT  = 12'b0_0_1_0_0_000_0_1_0_0;
  localparam logic [11:0] V_FRDY = 12'b1_1_1_0_0_000_0_1_0_0;
  localparam logic [11:0] V_BUSY = 12'b0_0_0_0_0_000_0_1_0_0;
  localparam logic [11:0] V_EXI  = 12'b0_0_0_0_0_001_0_1_0_0;
  localparam logic [11:0] V_MLW  = 12'b0_0_1_0_0_000_0_1_0_0;
  localparam logic [11:0] V_MSWD = 12'b0_0_0_1_0_000_0_1_1_0;
  localparam logic [11:0] V_WBA  = 12'b0_0_0_0_0_000_1_1_1_0;
  localparam logic [11:0] V_WBL  = 12'b0_0_0_0_1_000_1_1_1_0;
  localparam logic [11:0] V_ERR  = 12'b0_0_0_0_0_000_0_0_0_1;

  multicycle_control_fsm #(
    .MEM_TIMEOUT(15),
    .TO_W(4),
    .CNT_W(TB_CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .op(op),
    .mem_ready(mem_ready),
    .PCWrite(PCWrite),
    .IRWrite(IRWrite),
    .MemRead(MemRead),
    .MemToWrite(MemToWrite),
    .MemToReg(MemToReg),
    .ALUOp(ALUOp),
    .RegWrite(RegWrite),
    .busy(busy),
    .instr_done(instr_done),
    .instr_count(instr_count),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Retire scoreboard: each issued instruction pushes the counter value it
  // should leave behind; on every retire pulse the next value is popped and
  // compared once the counter has had its clock edge.
  always @(negedge clk) begin
    #2;
    if (!reset && instr_done === 1'b1) begin
      @(posedge clk);
      #1;
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL retire_count unexpected retire, instr_count=%0d", instr_count);
      end else begin
        logic [TB_CNT_W-1:0] e;
        e = expQ.pop_front();
        if (instr_count !== e) begin
          failures++;
          $display("FAIL retire_count got=%0d exp=%0d", instr_count, e);
        end
      end
    end
  end

  function automatic logic [11:0] outVec();
    return {PCWrite, IRWrite, MemRead, MemToWrite, MemToReg, ALUOp, RegWrite, busy, instr_done, error};
  endfunction

  task automatic pushRetire();
    expCount = (expCount + 1) % (1 << TB_CNT_W);
    expQ.push_back(TB_CNT_W'(expCount));
  endtask

  // One clock of stimulus; returns the outputs observed in that cycle.
  task automatic cyc(input logic r, input logic [5:0] o, input logic mr, output logic [11:0] v);
    @(negedge clk);
    run       = r;
    op        = o;
    mem_ready = mr;
    #1;
    v = outVec();
  endtask

  task automatic doReset();
    @(negedge clk);
    run       = 1'b0;
    mem_ready = 1'b0;
    reset     = 1'b1;
    expQ.delete();
    expCount  = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] v;
    reset = 1'b1; run = 1'b0; op = OP_R; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (outVec() !== V_IDLE || instr_count !== '0) begin
      failures++;
      $display("FAIL reset_hold outputs=%b count=%0d exp=%b count=0", outVec(), instr_count, V_IDLE);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, OP_R, 1'b1, v);
      checks++;
      if (v !== V_IDLE || instr_count !== '0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d outputs=%b count=%0d exp=%b count=0", i, v, instr_count, V_IDLE);
      end
    end
  endtask

  task automatic test_rtype();
    logic [11:0] v;
    logic [11:0] exp [6];
    logic [5:0]  rn;
    exp = '{V_IDLE, V_FRDY, V_BUSY, V_BUSY, V_WBA, V_IDLE};
    rn  = 6'b000001;  // bit i = run in cycle i
    pushRetire();
    for (int i = 0; i < 6; i++) begin
      cyc(rn[i], OP_R, 1'b1, v);
      checks++;
      if (v !== exp[i]) begin
        failures++;
        $display("FAIL rtype cyc%0d got=%b exp=%b", i, v, exp[i]);
      end
    end
  endtask

  task automatic test_lw();
    logic [11:0] v;
    logic [11:0] exp [10];
    logic [9:0]  rn;
    logic [9:0]  mr;
    exp = '{V_IDLE, V_FRDY, V_BUSY, V_EXI, V_MLW, V_MLW, V_MLW, V_MLW, V_WBL, V_IDLE};
    rn  = 10'b0000000001;  // run dropped right after issue
    mr  = 10'b0010000010;  // ready in FETCH and on the 4th MEM cycle
    pushRetire();
    for (int i = 0; i < 10; i++) begin
      cyc(rn[i], OP_LW, mr[i], v);
      checks++;
      if (v !== exp[i]) begin
        failures++;
        $display("FAIL lw cyc%0d got=%b exp=%b", i, v, exp[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [11:0] v;
    logic [11:0] exp [6];
    exp = '{V_IDLE, V_FRDY, V_BUSY, V_EXI, V_MSWD, V_IDLE};
    pushRetire();
    for (int i = 0; i < 6; i++) begin
      cyc(i == 0, OP_SW, 1'b1, v);
      checks++;
      if (v !== exp[i]) begin
        failures++;
        $display("FAIL sw cyc%0d got=%b exp=%b", i, v, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] v;
    logic [11:0] exp [10];
    logic [9:0]  rn;
    exp = '{V_IDLE, V_FRDY, V_BUSY, V_BUSY, V_WBA, V_FRDY, V_BUSY, V_EXI, V_WBA, V_IDLE};
    rn  = 10'b0000010001;  // run in IDLE and at the first retire
    pushRetire();
    pushRetire();
    for (int i = 0; i < 10; i++) begin
      // op switches to ADDI while the R-type is still in EXEC
      cyc(rn[i], (i < 3) ? OP_R : OP_ADDI, 1'b1, v);
      checks++;
      if (v !== exp[i]) begin
        failures++;
        $display("FAIL b2b cyc%0d got=%b exp=%b", i, v, exp[i]);
      end
    end
  endtask

  task automatic test_fetch_last_cycle_ready();
    logic [11:0] v;
    logic [11:0] e;
    pushRetire();
    for (int i = 0; i < 21; i++) begin
      if (i == 0)       e = V_IDLE;
      else if (i < 16)  e = V_FWT;
      else if (i == 16) e = V_FRDY;
      else if (i < 19)  e = V_BUSY;
      else if (i == 19) e = V_WBA;
      else              e = V_IDLE;
      cyc(i == 0, OP_R, i == 16, v);
      checks++;
      if (v !== e) begin
        failures++;
        $display("FAIL fetch_edge cyc%0d got=%b exp=%b", i, v, e);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [11:0] v;
    logic [11:0] exp [5];
    exp = '{V_IDLE, V_FRDY, V_BUSY, V_EXI, V_MLW};
    pushRetire();
    for (int i = 0; i < 5; i++) begin
      cyc(i == 0, OP_LW, i == 1, v);
      checks++;
      if (v !== exp[i]) begin
        failures++;
        $display("FAIL rst_mem cyc%0d got=%b exp=%b", i, v, exp[i]);
      end
    end
    #1;
    reset = 1'b1;
    expQ.delete();
    expCount = 0;
    #1;
    checks++;
    if (outVec() !== V_IDLE || instr_count !== '0) begin
      failures++;
      $display("FAIL rst_mem_async outputs=%b count=%0d exp=%b count=0", outVec(), instr_count, V_IDLE);
    end
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b0;
  endtask

  task automatic test_illegal();
    logic [11:0] v;
    logic [11:0] exp [3];
    exp = '{V_IDLE, V_FRDY, V_BUSY};
    for (int i = 0; i < 3; i++) begin
      cyc(i == 0, OP_BAD, 1'b1, v);
      checks++;
      if (v !== exp[i]) begin
        failures++;
        $display("FAIL illegal cyc%0d got=%b exp=%b", i, v, exp[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), v);
      checks++;
      if (v !== V_ERR) begin
        failures++;
        $display("FAIL illegal_sticky cyc%0d got=%b exp=%b", i, v, V_ERR);
      end
    end
  endtask

  task automatic test_fetch_timeout();
    logic [11:0] v;
    logic [11:0] e;
    for (int i = 0; i < 21; i++) begin
      if (i == 0)      e = V_IDLE;
      else if (i < 17) e = V_FWT;
      else             e = V_ERR;
      cyc((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), OP_R, (i < 17) ? 1'b0 : 1'($urandom_range(0, 1)), v);
      checks++;
      if (v !== e) begin
        failures++;
        $display("FAIL fetch_timeout cyc%0d got=%b exp=%b", i, v, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [11:0] v;
    int retires = 0;
    for (int k = 0; k < 256; k++) pushRetire();
    // Retire k lands in cycle 4k; run drops on the 256th retire.
    for (int i = 0; i <= 1025; i++) begin
      cyc(i != 1024, OP_R, 1'b1, v);
      if (v[1]) retires++;
      if (i == 1021) begin
        checks++;
        if (instr_count !== 8'hFF) begin
          failures++;
          $display("FAIL wrap_preload got=%0h exp=ff", instr_count);
        end
      end
    end
    checks++;
    if (retires != 256 || instr_count !== '0 || v !== V_IDLE) begin
      failures++;
      $display("FAIL wrap retires=%0d count=%0h outputs=%b exp retires=256 count=0 outputs=%b",
               retires, instr_count, v, V_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_back_to_back();
    test_fetch_last_cycle_ready();
    test_reset_mid_mem();
    test_rtype();
    test_illegal();
    doReset();
    test_fetch_timeout();
    doReset();
    test_wrap();
    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL pending_retires got=%0d exp=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
